// File: rtl/cnt_irq_pkg.sv
// cnt_irq_pkg: register map, bit positions, FSM states and bus types for cnt_irq_ctrl
package cnt_irq_pkg;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_EVCNT  = 2'd2;
  localparam int CTRL_IE      = 0;
  localparam int CTRL_EDGE    = 1;
  localparam int CTRL_HOLDOFF = 16;
  localparam int ST_PEND  = 0;
  localparam int ST_OVF   = 1;
  localparam int ST_HOLD  = 2;
  localparam int ST_DEFER = 3;
  typedef enum logic [1:0] {IDLE, PEND, HOLD} irq_state_e;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wdata, input logic [3:0] be);
    for (int b = 0; b < 4; b++) old[8*b +: 8] = be[b] ? wdata[8*b +: 8] : old[8*b +: 8];
    return old;
  endfunction
endpackage

// File: rtl/cnt_irq_holdoff.sv
// cnt_irq_holdoff: loadable down-counter; expire_o is high on the cycle the count sits at 1
// Ports: clk_i, rst_i (sync, active-high), load_i/value_i load the count, expire_o flags the last counted cycle.
module cnt_irq_holdoff #(
  parameter int HW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [HW-1:0] value_i,
  output logic          expire_o
);
  logic [HW-1:0] r_cnt;
  always_ff @(posedge clk_i)
    if (rst_i) r_cnt <= '0;
    else if (load_i) r_cnt <= value_i;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign expire_o = r_cnt == HW'(1);
endmodule

// File: rtl/cnt_irq_ctrl.sv
// cnt_irq_ctrl: terminal-count interrupt controller with hold-off moderation, sticky overflow and event counter
// Ports: clk_i/rst_i (sync, active-high); tc_i event source; bus_* OBI slave (CTRL 0x0, STATUS 0x4, EVCNT 0x8);
// irq_o level interrupt = IE & pending.
module cnt_irq_ctrl
  import cnt_irq_pkg::*;
#(
  parameter int HW = 16,
  parameter int CW = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tc_i,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [3:0]  bus_be_i,
  input  logic [31:0] bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  output logic        bus_gnt_o,
  output logic        bus_rvalid_o,
  output logic [31:0] bus_rdata_o,
  output logic        irq_o
);
  localparam logic [31:0] CTRL_MASK = 32'h3 | (32'((33'h1 << HW) - 33'h1) << CTRL_HOLDOFF);
  obi_req_t   w_req;
  obi_resp_t  w_resp;
  irq_state_e r_state, w_state_nxt;
  logic [31:0] r_ctrl, r_rdata, w_rdata;
  logic [CW-1:0] r_evcnt;
  logic r_tc_q, r_ovf, r_defer, r_rvalid;
  logic w_defer_nxt, w_ovf_set, w_load, w_expire;
  logic w_wr, w_evt, w_ack, w_ovf_clr, w_ev_clr, w_ctrl_wr;
  logic [1:0] w_sel;
  logic [HW-1:0] w_holdoff;
  logic w_unused;
  assign w_req     = '{req: bus_req_i, we: bus_we_i, be: bus_be_i, addr: bus_addr_i, wdata: bus_wdata_i};
  assign w_unused  = ^{w_req.addr[31:4], w_req.addr[1:0]};
  assign w_sel     = w_req.addr[3:2];
  assign w_wr      = w_req.req & w_req.we;
  assign w_ctrl_wr = w_wr & (w_sel == REG_CTRL);
  assign w_ack     = w_wr & (w_sel == REG_STATUS) & w_req.be[0] & w_req.wdata[ST_PEND];
  assign w_ovf_clr = w_wr & (w_sel == REG_STATUS) & w_req.be[0] & w_req.wdata[ST_OVF];
  assign w_ev_clr  = w_wr & (w_sel == REG_EVCNT) & (|w_req.be);
  assign w_evt     = r_ctrl[CTRL_EDGE] ? tc_i & ~r_tc_q : tc_i;
  assign w_holdoff = r_ctrl[CTRL_HOLDOFF +: HW];
  cnt_irq_holdoff #(.HW(HW)) u_holdoff (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (w_load),
    .value_i  (w_holdoff),
    .expire_o (w_expire)
  );
  always_comb begin
    w_state_nxt = r_state;
    w_defer_nxt = r_defer;
    w_ovf_set   = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = w_evt ? PEND : IDLE;
      PEND: begin
        if (w_ack && w_holdoff == '0) begin
          // an event coinciding with the ACK re-arms immediately instead of overflowing
          w_state_nxt = w_evt ? PEND : IDLE;
        end else if (w_ack) begin
          w_state_nxt = HOLD;
          w_load      = 1'b1;
          w_defer_nxt = w_evt;
        end else begin
          w_ovf_set = w_evt;
        end
      end
      HOLD: begin
        w_ovf_set   = w_evt & r_defer;
        w_defer_nxt = r_defer | w_evt;
        if (w_expire) begin
          w_state_nxt = (r_defer | w_evt) ? PEND : IDLE;
          w_defer_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  always_comb begin
    w_rdata = '0;
    case (w_sel)
      REG_CTRL:   w_rdata = r_ctrl;
      REG_STATUS: w_rdata = {28'b0, r_defer, r_state == HOLD, r_ovf, r_state == PEND};
      REG_EVCNT:  w_rdata = 32'(r_evcnt);
      default:    w_rdata = '0;
    endcase
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_state  <= IDLE;
      r_defer  <= 1'b0;
      r_ovf    <= 1'b0;
      r_tc_q   <= 1'b0;
      r_ctrl   <= '0;
      r_evcnt  <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_defer  <= w_defer_nxt;
      // a new overflow wins over a same-cycle clear so it is never silently lost
      r_ovf    <= w_ovf_set | (r_ovf & ~w_ovf_clr);
      r_tc_q   <= tc_i;
      r_ctrl   <= w_ctrl_wr ? be_merge(r_ctrl, w_req.wdata, w_req.be) & CTRL_MASK : r_ctrl;
      r_evcnt  <= w_ev_clr ? CW'(w_evt) : (w_evt && !(&r_evcnt)) ? r_evcnt + 1'b1 : r_evcnt;
      r_rvalid <= w_req.req;
      r_rdata  <= (w_req.req && !w_req.we) ? w_rdata : '0;
    end
  assign w_resp       = '{gnt: w_req.req, rvalid: r_rvalid, rdata: r_rdata};
  assign bus_gnt_o    = w_resp.gnt;
  assign bus_rvalid_o = w_resp.rvalid;
  assign bus_rdata_o  = w_resp.rdata;
  assign irq_o        = r_ctrl[CTRL_IE] & (r_state == PEND);
endmodule

// File: tb/tb_cnt_irq_ctrl.sv
// tb_cnt_irq_ctrl: scoreboard bench for cnt_irq_ctrl against an abstract reference model
module tb_cnt_irq_ctrl;
  localparam int HW = 16;
  localparam int CW = 2;
  localparam int EVMAX = (1 << CW) - 1;
  logic clk = 0, rst = 1, tc = 0, req = 0, we = 0;
  logic [3:0] be = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic gnt, rvalid, irq;
  logic [31:0] rdata;
  always #5 clk = ~clk;
  cnt_irq_ctrl #(.HW(HW), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst), .tc_i(tc), .bus_req_i(req), .bus_we_i(we), .bus_be_i(be),
    .bus_addr_i(addr), .bus_wdata_i(wdata), .bus_gnt_o(gnt), .bus_rvalid_o(rvalid),
    .bus_rdata_o(rdata), .irq_o(irq)
  );
  // reference model: mode 0 idle, 1 pending, 2 holding off with m_left cycles still to wait
  logic [31:0] m_ctrl;
  bit m_ovf, m_defer, m_tcq, m_rv, m_irq, started;
  int m_ev, m_mode, m_left;
  logic [31:0] q[$];
  int n_cmp = 0, n_bad = 0;
  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[3:2])
      2'd0: return m_ctrl;
      2'd1: return {28'b0, m_defer, m_mode == 2, m_ovf, m_mode == 1};
      2'd2: return 32'(m_ev);
      default: return 32'h0;
    endcase
  endfunction
  function automatic void m_reset();
    m_ctrl = 0; m_ovf = 0; m_defer = 0; m_tcq = 0; m_rv = 0; m_irq = 0;
    m_ev = 0; m_mode = 0; m_left = 0;
  endfunction
  function automatic void m_step(input bit t, input bit rq, input bit w, input logic [3:0] b,
                                 input logic [31:0] a, input logic [31:0] d);
    bit evt, ack, clr, ovf_set;
    int h, mode, left;
    bit defer;
    evt = m_ctrl[1] ? (t && !m_tcq) : t;
    ack = rq && w && a[3:2] == 1 && b[0] && d[0];
    clr = rq && w && a[3:2] == 1 && b[0] && d[1];
    h = int'(m_ctrl[31:16]);
    mode = m_mode; left = m_left; defer = m_defer; ovf_set = 0;
    if (m_mode == 0) begin
      if (evt) mode = 1;
    end else if (m_mode == 1) begin
      if (ack && h == 0) mode = evt ? 1 : 0;
      else if (ack) begin mode = 2; left = h; defer = evt; end
      else ovf_set = evt;
    end else begin
      if (evt && m_defer) ovf_set = 1;
      if (m_left == 1) begin mode = (m_defer || evt) ? 1 : 0; defer = 0; end
      else begin left = m_left - 1; if (evt) defer = 1; end
    end
    m_ovf = ovf_set || (m_ovf && !clr);
    if (rq && w && a[3:2] == 2 && b != 0) m_ev = evt ? 1 : 0;
    else if (evt && m_ev < EVMAX) m_ev++;
    if (rq && w && a[3:2] == 0) begin
      for (int i = 0; i < 4; i++) if (b[i]) m_ctrl[8*i +: 8] = d[8*i +: 8];
      m_ctrl &= 32'hffff_0003;
    end
    m_mode = mode; m_left = left; m_defer = defer;
    m_tcq = t; m_rv = rq;
    m_irq = m_ctrl[0] && m_mode == 1;
  endfunction
  task automatic cyc(input bit t, input bit rq, input bit w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d);
    tc = t; req = rq; we = w; be = b; addr = a; wdata = d;
    if (rq) q.push_back(w ? 32'h0 : m_read(a));
    @(posedge clk);
    m_step(t, rq, w, b, a, d);
    #1;
  endtask
  task automatic idle(input bit t); cyc(t, 0, 0, 4'h0, 0, 0); endtask
  task automatic rd(input logic [31:0] a); cyc(0, 1, 0, 4'h0, a, 0); endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b); cyc(0, 1, 1, b, a, d); endtask
  task automatic do_reset();
    tc = 0; req = 0; we = 0; be = 0; addr = 0; wdata = 0; rst = 1;
    @(posedge clk);
    m_reset();
    #1 rst = 0;
  endtask
  always @(negedge clk) if (started) begin
    n_cmp++;
    if (gnt !== req) begin n_bad++; $display("FAIL gnt: got %b want %b", gnt, req); end
    n_cmp++;
    if (rvalid !== m_rv) begin n_bad++; $display("FAIL rvalid: got %b want %b", rvalid, m_rv); end
    n_cmp++;
    if (irq !== m_irq) begin n_bad++; $display("FAIL irq: got %b want %b at %0t", irq, m_irq, $time); end
    if (rvalid === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin n_bad++; $display("FAIL rdata: rvalid with no request outstanding"); end
      else begin
        logic [31:0] e;
        e = q.pop_front();
        if (rdata !== e) begin n_bad++; $display("FAIL rdata: got %h want %h at %0t", rdata, e, $time); end
      end
    end
  end
  initial begin
    do_reset();
    do_reset();
    started = 1;
    rd(0); rd(4); rd(8);
    wr(0, 32'h3, 4'hf); repeat (5) idle(1); idle(0); rd(4); rd(8);
    do_reset();
    wr(0, 32'h1, 4'hf); repeat (3) idle(1); idle(0); rd(4); rd(8); wr(4, 32'h2, 4'h1); rd(4);
    do_reset();
    wr(0, 32'h0004_0001, 4'hf); idle(1); idle(0); wr(4, 32'h1, 4'h1); rd(4); repeat (4) idle(0); rd(4);
    idle(1); idle(0); wr(4, 32'h1, 4'h1); idle(1); idle(0); repeat (3) idle(0); rd(4); rd(8);
    wr(0, 32'h1, 4'hf); idle(0); wr(4, 32'h1, 4'h1); idle(1); cyc(1, 1, 1, 4'h1, 4, 32'h1); idle(0); rd(4);
    wr(0, 32'h0002_0001, 4'hf); idle(1); cyc(1, 1, 1, 4'h1, 4, 32'h1); idle(0); rd(4); idle(0); rd(4);
    do_reset();
    idle(1); idle(0); rd(4); wr(0, 32'h1, 4'hf); idle(0); wr(0, 32'h0009_0000, 4'h1); rd(0);
    rd(12); wr(12, 32'hffff_ffff, 4'hf); rd(12);
    do_reset();
    repeat (5) idle(1); idle(0); rd(8); wr(8, 32'h0, 4'h2); rd(8); cyc(1, 1, 1, 4'h1, 8, 0); idle(0); rd(8);
    wr(0, 32'h0006_0001, 4'hf); idle(1); idle(0); wr(4, 32'h1, 4'h1); idle(0); idle(1); rd(4);
    do_reset(); rd(0); rd(4); rd(8); idle(0);
    for (int n = 0; n < 3000; n++) begin
      bit t;
      int op;
      logic [3:0] b;
      t = $urandom_range(0, 3) == 0;
      op = $urandom_range(0, 9);
      b = $urandom_range(0, 1) ? 4'hf : 4'($urandom_range(0, 15));
      case (op)
        0, 1: cyc(t, 1, 0, 4'h0, {$urandom} & 32'hffff_fffc | 32'($urandom_range(0, 3)), 0);
        2: cyc(t, 1, 1, b, 0, {16'($urandom_range(0, 5)), 14'($urandom), 2'($urandom)});
        3, 4: cyc(t, 1, 1, b, 4, {30'($urandom), 2'($urandom_range(0, 3))});
        5: cyc(t, 1, 1, b, 8, $urandom);
        6: cyc(t, 1, 1, b, 12, $urandom);
        default: idle(t);
      endcase
      if ($urandom_range(0, 499) == 0) begin idle(0); idle(0); do_reset(); end
    end
    idle(0); idle(0);
    n_cmp++;
    if (q.size() != 0) begin n_bad++; $display("FAIL outstanding: got %0d want 0", q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
